// File: rtl/sd_sched_pkg.sv
// Shared types and constants for the SD read scheduler.
// Optional build macro used by the top: SCHED_TIMEOUT_EN.
package sd_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    localparam logic OWNER_TILE = 1'b0;
    localparam logic OWNER_AUD  = 1'b1;

    localparam int SECTOR_BYTES_DEF = 512;

endpackage

// File: rtl/sd_sched_arbiter.sv
// Audio-over-tile priority with a bounded audio burst so tiles never starve.
module sd_sched_arbiter
    import sd_sched_pkg::*;
#(
    parameter int MAX_AUD_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic tile_req,
    input  logic aud_req,
    output logic grant,
    output logic grant_owner
);

    localparam int BW = $clog2(MAX_AUD_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_AUD_BURST);

    logic [BW-1:0] burst_q, burst_d;
    logic          aud_win;

    always_comb begin
        aud_win     = aud_req && ((burst_q < BURST_MAX) || !tile_req);
        grant       = arb_en && (aud_req || tile_req);
        grant_owner = aud_win ? OWNER_AUD : OWNER_TILE;
        burst_d     = burst_q;
        if (grant) begin
            if (!aud_win) begin
                burst_d = '0;
            end else if (burst_q != BURST_MAX) begin
                burst_d = burst_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

endmodule

// File: rtl/sd_read_scheduler.sv
// Shares one SD_SPI read stream between tile loader and audio refill.
// Build with SCHED_TIMEOUT_EN to add the byte-gap watchdog.
module sd_read_scheduler
    import sd_sched_pkg::*;
#(
    parameter int ADDR_W         = 24,
    parameter int SECTOR_BYTES   = SECTOR_BYTES_DEF,
    parameter int MAX_AUD_BURST  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                            MasterCLK,
    input  logic                            Reset,
    input  logic                            SdByteStrobe,
    input  logic                            SdDataEnable,
    input  logic [7:0]                      SdData,
    output logic [ADDR_W-1:0]               SdAddress,
    input  logic                            TileReq,
    input  logic [ADDR_W-1:0]               TileAddr,
    input  logic                            AudReq,
    input  logic [ADDR_W-1:0]               AudAddr,
    output logic                            ByteValid,
    output logic [7:0]                      ByteData,
    output logic                            ByteOwner,
    output logic [$clog2(SECTOR_BYTES)-1:0] ByteIndex,
    output logic                            TileDone,
    output logic                            AudDone,
    output logic                            Busy,
    output logic                            SchedError
);

    localparam int IDX_W = $clog2(SECTOR_BYTES);

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               strobe_q;
    logic               valid_q, valid_d;
    logic [7:0]         data_q, data_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               bown_q, bown_d;
    logic               grant, grant_owner;
    logic               in_xfer, take, timeout;

    sd_sched_arbiter #(
        .MAX_AUD_BURST(MAX_AUD_BURST)
    ) u_arb (
        .clk        (MasterCLK),
        .rst_n      (Reset),
        .arb_en     (state_q == S_IDLE),
        .tile_req   (TileReq),
        .aud_req    (AudReq),
        .grant      (grant),
        .grant_owner(grant_owner)
    );

    assign in_xfer = (state_q == S_WAIT) || (state_q == S_STREAM);
    assign take    = SdByteStrobe && !strobe_q && SdDataEnable && in_xfer;

`ifdef SCHED_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             err_q, err_d;

    always_comb begin
        timeout = in_xfer && !take && (gap_q == GAP_W'(TIMEOUT_CYCLES));
        gap_d   = (in_xfer && !take) ? gap_q + 1'b1 : '0;
        err_d   = err_q || timeout;
    end

    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            gap_q <= '0;
            err_q <= 1'b0;
        end else begin
            gap_q <= gap_d;
            err_q <= err_d;
        end
    end

    assign SchedError = err_q;
`else
    assign timeout    = 1'b0;
    assign SchedError = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        data_d  = data_q;
        idx_d   = idx_q;
        bown_d  = bown_q;
        if (take) begin
            valid_d = 1'b1;
            data_d  = SdData;
            idx_d   = cnt_q;
            bown_d  = owner_q;
            cnt_d   = cnt_q + 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (grant) begin
                    owner_d = grant_owner;
                    addr_d  = (grant_owner == OWNER_AUD) ? AudAddr : TileAddr;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (take) state_d = S_STREAM;
                else if (timeout) state_d = S_DONE;
            end
            S_STREAM: begin
                // Counter is a power of two wide, so all-ones marks the last byte.
                if (take && (&cnt_q)) state_d = S_DONE;
                else if (timeout) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            owner_q  <= OWNER_TILE;
            addr_q   <= '0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            idx_q    <= '0;
            bown_q   <= OWNER_TILE;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            strobe_q <= SdByteStrobe;
            valid_q  <= valid_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            bown_q   <= bown_d;
        end
    end

    assign SdAddress = addr_q;
    assign ByteValid = valid_q;
    assign ByteData  = data_q;
    assign ByteOwner = bown_q;
    assign ByteIndex = idx_q;
    assign Busy      = (state_q != S_IDLE);
    assign TileDone  = (state_q == S_DONE) && (owner_q == OWNER_TILE);
    assign AudDone   = (state_q == S_DONE) && (owner_q == OWNER_AUD);

endmodule

// File: tb/tb_sd_read_scheduler.sv
// Directed scoreboard bench for sd_read_scheduler (default build).
module tb_sd_read_scheduler;
    import sd_sched_pkg::*;

    logic        clk = 1'b0;
    logic        Reset;
    logic        SdByteStrobe, SdDataEnable;
    logic [7:0]  SdData;
    logic [23:0] SdAddress, TileAddr, AudAddr;
    logic        TileReq, AudReq;
    logic        ByteValid, ByteOwner, TileDone, AudDone, Busy, SchedError;
    logic [7:0]  ByteData;
    logic [8:0]  ByteIndex;

    typedef struct packed {
        logic       own;
        logic [8:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0, failures = 0;
    int tdone_cnt = 0, adone_cnt = 0;
    int exp_tdone = 0, exp_adone = 0;

    always #5 clk = ~clk;

    sd_read_scheduler dut (
        .MasterCLK   (clk),
        .Reset       (Reset),
        .SdByteStrobe(SdByteStrobe),
        .SdDataEnable(SdDataEnable),
        .SdData      (SdData),
        .SdAddress   (SdAddress),
        .TileReq     (TileReq),
        .TileAddr    (TileAddr),
        .AudReq      (AudReq),
        .AudAddr     (AudAddr),
        .ByteValid   (ByteValid),
        .ByteData    (ByteData),
        .ByteOwner   (ByteOwner),
        .ByteIndex   (ByteIndex),
        .TileDone    (TileDone),
        .AudDone     (AudDone),
        .Busy        (Busy),
        .SchedError  (SchedError)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (TileDone === 1'b1) tdone_cnt++;
        if (AudDone === 1'b1) adone_cnt++;
        if (ByteValid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_byte", ByteValid, 0);
            end else begin
                e = sb.pop_front();
                chk("byte_data", ByteData, e.data);
                chk("byte_owner", ByteOwner, e.own);
                chk("byte_index", ByteIndex, e.idx);
            end
        end
    end

    task automatic strobe(input bit exp, input logic own, input int idx);
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        @(negedge clk);
        SdData = d;
        SdByteStrobe = 1'b1;
        if (exp) sb.push_back('{own: own, idx: 9'(idx), data: d});
        @(negedge clk);
        SdByteStrobe = 1'b0;
    endtask

    task automatic send_run(input logic own, input int first, input int last);
        for (int i = first; i <= last; i++) strobe(1'b1, own, i);
    endtask

    task automatic wait_busy(input logic [23:0] addr);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (Busy === 1'b1) break;
        end
        chk("grant_busy", Busy, 1);
        chk("grant_addr", SdAddress, addr);
    endtask

    task automatic finish_sector(input logic own, input bit drop);
        chk("tile_done", TileDone, own == OWNER_TILE);
        chk("aud_done", AudDone, own == OWNER_AUD);
        if (own == OWNER_AUD) exp_adone++;
        else exp_tdone++;
        if (drop) begin
            if (own == OWNER_AUD) AudReq = 1'b0;
            else TileReq = 1'b0;
        end
        @(negedge clk);
        chk("idle_busy", Busy, 0);
    endtask

    task automatic full_sector(input logic own, input logic [23:0] addr,
                               input bit drop);
        wait_busy(addr);
        send_run(own, 0, 511);
        finish_sector(own, drop);
    endtask

    initial begin
        Reset = 1'b0;
        SdByteStrobe = 1'b0;
        SdDataEnable = 1'b1;
        SdData = 8'h00;
        TileReq = 1'b0;
        AudReq = 1'b0;
        TileAddr = 24'h0;
        AudAddr = 24'h0;
        repeat (2) @(negedge clk);
        chk("rst_addr", SdAddress, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_valid", ByteValid, 0);
        chk("rst_err", SchedError, 0);
        Reset = 1'b1;

        // Tile only
        @(negedge clk);
        TileAddr = 24'h000014;
        TileReq = 1'b1;
        full_sector(OWNER_TILE, 24'h000014, 1'b1);

        // Audio raised at byte 100 of a tile sector
        TileAddr = 24'h000020;
        TileReq = 1'b1;
        wait_busy(24'h000020);
        send_run(OWNER_TILE, 0, 99);
        AudAddr = 24'h000100;
        AudReq = 1'b1;
        send_run(OWNER_TILE, 100, 511);
        finish_sector(OWNER_TILE, 1'b1);
        @(negedge clk);
        chk("aud_after_tile_busy", Busy, 1);
        chk("aud_after_tile_addr", SdAddress, 24'h000100);

        // Reset in the middle of an audio sector
        send_run(OWNER_AUD, 0, 299);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        chk("midrst_addr", SdAddress, 0);
        chk("midrst_busy", Busy, 0);
        chk("midrst_owner", ByteOwner, 0);
        chk("midrst_index", ByteIndex, 0);
        chk("midrst_data", ByteData, 0);
        chk("midrst_auddone", AudDone, 0);
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        full_sector(OWNER_AUD, 24'h000100, 1'b1);

        // Disabled strobes in WAIT, requester drops mid-sector
        TileAddr = 24'h000033;
        TileReq = 1'b1;
        wait_busy(24'h000033);
        SdDataEnable = 1'b0;
        repeat (3) strobe(1'b0, OWNER_TILE, 0);
        SdDataEnable = 1'b1;
        send_run(OWNER_TILE, 0, 9);
        TileReq = 1'b0;
        send_run(OWNER_TILE, 10, 511);
        finish_sector(OWNER_TILE, 1'b0);

        // Both requesters high from reset
        @(negedge clk);
        Reset = 1'b0;
        TileAddr = 24'h000200;
        AudAddr = 24'h000100;
        TileReq = 1'b1;
        AudReq = 1'b1;
        @(negedge clk);
        Reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) full_sector(OWNER_TILE, 24'h000200, k == 9);
            else full_sector(OWNER_AUD, 24'h000100, 1'b0);
        end

        // Audio alone for many grants: burst must saturate, not wrap
        for (int k = 0; k < 8; k++) full_sector(OWNER_AUD, 24'h000100, 1'b0);
        TileReq = 1'b1;
        full_sector(OWNER_TILE, 24'h000200, 1'b1);
        AudReq = 1'b0;

        repeat (4) @(negedge clk);
        chk("tile_done_total", tdone_cnt, exp_tdone);
        chk("aud_done_total", adone_cnt, exp_adone);
        chk("sb_empty", sb.size(), 0);
        chk("final_busy", Busy, 0);
        chk("final_err", SchedError, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_read_scheduler.md
Name: sd_read_scheduler

Overview:
Sector-level arbiter and sequencer sharing the single SD_SPI read stream between two requesters: the tile loader (bulk, low priority) and the audio refill logic (deadline, high priority). Owns the SD_SPI InputAddress and counts streamed bytes per sector. Tags each byte with its owner and index, and reports per-sector completion. Sits between SD_SPI and the tile/audio consumers inside AudVid.

Parameters:
ADDR_W, 24, SD block address width (matches SD_SPI InputAddress)
SECTOR_BYTES, 512, bytes per granted transfer; power of two
MAX_AUD_BURST, 4, consecutive audio grants allowed while a tile request waits
TIMEOUT_CYCLES, 65535, byte-gap watchdog limit (only with SCHED_TIMEOUT_EN)

Ports:
MasterCLK  in  1  system clock
Reset  in  1  asynchronous active-low reset
SdByteStrobe  in  1  SD_SPI InputDataClock, synchronous to MasterCLK; rising edge = new byte
SdDataEnable  in  1  SD_SPI EnableDataRead; card is streaming data
SdData  in  8  SD_SPI InputData
SdAddress  out  ADDR_W  block address to SD_SPI
TileReq  in  1  tile loader requests one sector; held until TileDone
TileAddr  in  ADDR_W  tile sector address, stable while TileReq is high
AudReq  in  1  audio requests one sector; held until AudDone
AudAddr  in  ADDR_W  audio sector address, stable while AudReq is high
ByteValid  out  1  one-cycle pulse per accepted byte
ByteData  out  8  registered byte
ByteOwner  out  1  0 = tile, 1 = audio
ByteIndex  out  log2(SECTOR_BYTES)  byte position in sector, 0..SECTOR_BYTES-1
TileDone  out  1  one-cycle pulse when a tile sector completes
AudDone  out  1  one-cycle pulse when an audio sector completes
Busy  out  1  high from grant until the DONE state exits
SchedError  out  1  sticky watchdog error (tied 0 without SCHED_TIMEOUT_EN)

Behaviour:
- Reset (async, Reset=0): state IDLE; SdAddress=0; all pulses 0; ByteData=0; ByteOwner=0; ByteIndex=0; Busy=0; burst counter=0; SchedError=0; strobe edge register=0.
- Byte acceptance: a byte is accepted when SdByteStrobe is high, its previous sample was low, and SdDataEnable=1. ByteData/ByteValid/ByteIndex are registered: valid 1 cycle after the edge is sampled.
- IDLE: if AudReq and (burst<MAX_AUD_BURST or !TileReq) -> grant audio and increment burst. Else if TileReq -> grant tile and clear burst to 0. Grant latches owner and SdAddress <= AudAddr or TileAddr. Go to WAIT with Busy=1.
- Simultaneous AudReq and TileReq with burst<MAX_AUD_BURST: audio wins. With burst==MAX_AUD_BURST: tile wins.
- If AudReq alone is granted while burst==MAX_AUD_BURST, burst saturates at MAX_AUD_BURST and does not wrap.
- WAIT: bytes arriving before SdDataEnable rises are ignored. On the first accepted byte go to STREAM and count it as index 0.
- STREAM: each accepted byte increments the byte counter. The counter wraps to 0 after SECTOR_BYTES-1. The byte at index SECTOR_BYTES-1 moves the FSM to DONE.
- DONE (1 cycle): pulse TileDone or AudDone per the latched owner; Busy=0 on exit; return to IDLE. A new grant can happen no earlier than the cycle after DONE.
- SdAddress holds its value outside grants. Requests are non-preemptive: an AudReq during a tile sector waits until that sector finishes.
- Requester dropping its req mid-sector: the sector still completes and the Done pulse is still issued.
- Reset asserted mid-sector: immediate return to IDLE. No Done pulse. Partial data is the consumer's problem.

Optional Feature:
SCHED_TIMEOUT_EN: adds a gap counter in WAIT/STREAM, cleared on each accepted byte. When the counter reaches TIMEOUT_CYCLES: set SchedError (sticky until reset), pulse the owner's Done, and return to IDLE. Without the macro: no counter, SchedError tied 0, and the FSM waits indefinitely.

Decomposition:
- Shared package sd_sched_pkg: state enum (IDLE, WAIT, STREAM, DONE), owner constants OWNER_TILE=0 and OWNER_AUD=1, SECTOR_BYTES default.
- One natural sub-module, sd_sched_arbiter: combinational priority plus the registered burst counter. It produces grant and owner for the FSM.

Test Plan:
- Only TileReq, TileAddr=0x000014; 512 strobes with SdDataEnable=1 -> SdAddress=0x000014, 512 ByteValid with ByteOwner=0 and ByteIndex 0..511, one TileDone.
- TileReq and AudReq both high from reset, AudAddr=0x000100 -> grants in order A,A,A,A,T,A,A,A,A,T; burst resets after each tile grant.
- AudReq raised during tile sector at byte 100 -> tile sector finishes with 512 bytes; audio granted the cycle after TileDone.
- Strobes with SdDataEnable=0 in WAIT, then enable -> the first enabled byte has ByteIndex=0; earlier bytes produce no ByteValid.
- Reset pulsed low at byte 300 of an audio sector -> all outputs at reset values asynchronously, no AudDone; the next grant restarts at ByteIndex 0.
- SCHED_TIMEOUT_EN with TIMEOUT_CYCLES=100; strobes stop at byte 10 -> SchedError=1 after 100 idle cycles, one Done pulse, FSM back to IDLE.
